fetch_prefetch_queue: RTL and testbench

//  Instruction prefetch stage upstream of the fetch/decode pipeline register.

---
 rtl/fetch_prefetch_queue.sv | 196 +++++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Sequential-PC instruction prefetcher with an in-order DEPTH-entry FIFO; redirect flushes and restarts.
// Latency: imem response -> inst_valid 1 cycle; backpressure: requests credit-gated on FIFO space, inst_ready stalls head.

module fpq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_vld) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_rdy) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_vld, pop_rdy})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  assert property (@(posedge clk) disable iff (!rst) count_q <= FULL);
  assert property (@(posedge clk) disable iff (!rst) !(push_vld && !flush && count_q == FULL));
  assert property (@(posedge clk) disable iff (!rst) !(pop_rdy && !flush && count_q == '0));

endmodule

module fetch_prefetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);
  localparam int            CW         = $clog2(DEPTH) + 1;
  localparam int            OW         = $clog2(MAX_OUTSTANDING + 1);
  localparam int            SW         = $clog2(DEPTH + MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] CREDIT_MAX = SW'(DEPTH);
  localparam logic [31:0]   NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic [SW-1:0] inflight;
  logic          issue;
  logic          push_vld;
  logic          pop_rdy;
  inst_t         push_dat;
  inst_t         head_dat;

  // Credit: every live (non-discarded) request already owns a FIFO slot.
  always_comb begin
    inflight       = SW'(fifo_count) + SW'(outst_q) - SW'(discard_q);
    imem_req_valid = rst && !redirect && (outst_q < OUT_MAX) && (inflight < CREDIT_MAX);
    issue          = imem_req_valid && imem_req_ready;
    push_vld       = imem_rsp_valid && !redirect && (discard_q == '0);
    pop_rdy        = inst_valid && inst_ready && !redirect;
    push_dat       = '{pc: rsp_pc_q, data: imem_rsp_data};
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (issue && !imem_rsp_valid) begin
      outst_d = outst_q + OW'(1);
    end else if (!issue && imem_rsp_valid) begin
      outst_d = outst_q - OW'(1);
    end
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      discard_d  = imem_rsp_valid ? outst_q - OW'(1) : outst_q;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - OW'(1);
        end else begin
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fpq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(inst_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (pop_rdy),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  always_comb begin
    imem_req_addr = fetch_pc_q;
    inst_valid    = (fifo_count != '0);
    inst_data     = inst_valid ? head_dat.data : NOP;
    inst_pc       = inst_valid ? head_dat.pc : 32'h0;
  end

  assert property (@(posedge clk) disable iff (!rst) outst_q <= OUT_MAX);
  assert property (@(posedge clk) disable iff (!rst) discard_q <= outst_q);
  assert property (@(posedge clk) disable iff (!rst) !(imem_rsp_valid && outst_q == '0));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order memory model with variable latency, scoreboard of expected PCs.
module tb_fetch_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  fetch_prefetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          cyc       = 0;
  int          lat       = 1;
  int          last_due  = 0;
  int          mdue      = 0;
  int          pops_left = 0;
  int          n_issued  = 0;
  int          n_popped  = 0;
  int          found     = 0;
  bit          rnd_ready = 0;
  bit          hold_vld  = 0;
  logic [31:0] hold_addr;
  logic [31:0] exp_next_pc;
  logic [31:0] mon_e;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // Main stimulus acts at negedge+1; memory drives at negedge, samplers at negedge+2.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic consume(input int k);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(exp_next_pc);
      exp_next_pc = exp_next_pc + 32'd4;
    end
    pops_left = k;
    for (int c = 0; c < 2000 && pops_left > 0; c++) begin
      inst_ready = 1'b1;
      step();
    end
    inst_ready = 1'b0;
    chk("consume_done", 32'(pops_left), 32'd0);
    pops_left = 0;
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-order instruction memory, no response backpressure.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_fn(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
      imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #2;
      if (!rst) begin
        mq.delete();
        last_due = 0;
        hold_vld = 1'b0;
      end else begin
        if (redirect) hold_vld = 1'b0;
        if (imem_req_valid) begin
          if (hold_vld) chk("req_addr_hold", imem_req_addr, hold_addr);
          if (imem_req_ready) begin
            mdue = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{addr: imem_req_addr, due: mdue});
            last_due = mdue;
            n_issued++;
            hold_vld = 1'b0;
          end else begin
            hold_vld  = 1'b1;
            hold_addr = imem_req_addr;
          end
        end
      end
    end
  end

  // Scoreboard monitor: compares every consumed instruction with the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && inst_valid && inst_ready && !redirect) begin
        n_popped++;
        if (pops_left > 0) pops_left--;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h, required no instruction", inst_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("inst_pc", inst_pc, mon_e);
          chk("inst_data", inst_data, mem_fn(mon_e));
        end
      end else if (inst_valid === 1'b0) begin
        chk("idle_inst_data", inst_data, NOP);
        chk("idle_inst_pc", inst_pc, 32'h0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    exp_next_pc = RESET_PC;
    step();
    step();
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_data", inst_data, NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    rst = 1'b1;

    // Streaming with 1-cycle memory.
    consume(8);

    // Stall: FIFO fills and credit stops requests.
    repeat (12) step();
    chk1("stall_req_valid", imem_req_valid, 1'b0);
    chk1("stall_inst_valid", inst_valid, 1'b1);
    chk("stall_credit", 32'(n_issued - n_popped), 32'(DEPTH));
    consume(8);

    // Redirect with two requests outstanding at 3-cycle latency.
    lat = 3;
    repeat (12) step();
    consume(2);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (mq.size() == 2 && !imem_rsp_valid) begin
        found = 1;
        break;
      end
      step();
    end
    chk("t3_two_outstanding", 32'(found), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk1("redir_blocks_req", imem_req_valid, 1'b0);
    step();
    redirect    = 1'b0;
    exp_next_pc = 32'h100;
    n_issued    = 0;
    n_popped    = 0;
    consume(4);

    // Redirect coinciding with a response and a pop.
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (imem_rsp_valid && inst_valid) begin
        found = 1;
        break;
      end
      step();
    end
    chk("t4_rsp_with_valid", 32'(found), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    inst_ready  = 1'b1;
    step();
    redirect    = 1'b0;
    inst_ready  = 1'b0;
    exp_next_pc = 32'h200;
    chk1("t4_flush_empty", inst_valid, 1'b0);
    consume(6);

    // Random request acceptance.
    lat       = 1;
    rnd_ready = 1'b1;
    consume(16);
    rnd_ready = 1'b0;

    // Reset mid-stream.
    step();
    step();
    chk1("pre_rst_valid", inst_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk1("rst_forces_req_low", imem_req_valid, 1'b0);
    step();
    chk1("mid_rst_inst_valid", inst_valid, 1'b0);
    chk("mid_rst_inst_data", inst_data, NOP);
    chk("mid_rst_inst_pc", inst_pc, 32'h0);
    chk("mid_rst_req_addr", imem_req_addr, RESET_PC);
    rst         = 1'b1;
    exp_next_pc = RESET_PC;
    consume(4);

    repeat (4) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
